seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/rv_div_pkg.sv | 28 ++
 rtl/cla_sub.sv | 35 +++
 rtl/seq_divider.sv | 137 +++++++++++++
 tb/tb_seq_divider.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rv_div_pkg.sv
// Shared definitions for the sequential RISC-V divider: op encodings, FSM states, width default.
package rv_div_pkg;

  localparam int XLEN_DEF = 64;

  // Matches funct3[1:0] of DIV/DIVU/REM/REMU.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/cla_sub.sv
// Parallel-prefix (carry-lookahead) subtractor: diff = a + ~b + 1, no_borrow = carry out.
module cla_sub #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] diff,
  output logic            no_borrow
);

  localparam int LV = $clog2(XLEN);

  logic [XLEN-1:0] b_inv;
  logic [XLEN-1:0] p0;
  logic [XLEN-1:0] gk [0:LV];
  logic [XLEN-1:0] pk [0:LV-1];

  assign b_inv = ~b;
  assign p0    = a ^ b_inv;
  assign pk[0] = p0;
  // The constant carry-in is folded into bit 0's generate term.
  assign gk[0] = {a[XLEN-1:1] & b_inv[XLEN-1:1], a[0] | b_inv[0]};

  for (genvar l = 0; l < LV; l++) begin : g_prefix
    localparam int D = 1 << l;
    assign gk[l+1] = gk[l] | (pk[l] & {gk[l][XLEN-1-D:0], {D{1'b0}}});
    if (l + 1 < LV) begin : g_prop
      assign pk[l+1] = pk[l] & {pk[l][XLEN-1-D:0], {D{1'b1}}};
    end
  end

  assign diff      = p0 ^ {gk[LV][XLEN-2:0], 1'b1};
  assign no_borrow = gk[LV][XLEN-1];

endmodule

// File: rtl/seq_divider.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU: one quotient bit per BUSY cycle,
// divide-by-zero and signed overflow resolved at acceptance without entering BUSY.
module seq_divider
  import rv_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            in_signed, dvd_neg, dsr_neg, div_zero, sgn_ovf;
  logic [XLEN-1:0] dvd_mag, dsr_mag;
  logic [XLEN-1:0] shifted, diff, quo_next, rem_next, quo_fix, rem_fix;
  logic            no_borrow, take, last;

  assign in_signed = op_is_signed(op);
  assign dvd_neg   = in_signed & dividend[XLEN-1];
  assign dsr_neg   = in_signed & divisor[XLEN-1];
  assign dvd_mag   = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dsr_mag   = dsr_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero  = (divisor == '0);
  assign sgn_ovf   = in_signed && (dividend == MIN_NEG) && (&divisor);

  // A set remainder MSB means the shifted value exceeds XLEN bits and always beats the divisor.
  assign shifted  = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign take     = rem_q[XLEN-1] | no_borrow;
  assign quo_next = {quo_q[XLEN-2:0], take};
  assign rem_next = take ? diff : shifted;
  assign quo_fix  = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
  assign rem_fix  = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
  assign last     = (cnt_q == CW'(XLEN - 1));

  cla_sub #(.XLEN(XLEN)) u_sub (
    .a         (shifted),
    .b         (dsr_q),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d      = op;
          neg_quo_d = dvd_neg ^ dsr_neg;
          neg_rem_d = dvd_neg;
          quo_d     = dvd_mag;
          rem_d     = '0;
          dsr_d     = dsr_mag;
          cnt_d     = '0;
          if (div_zero) begin
            result_d = op_is_rem(op) ? dividend : '1;
            state_d  = DONE;
          end else if (sgn_ovf) begin
            result_d = op_is_rem(op) ? '0 : dividend;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        quo_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider with hand-computed results and edge-count latency checks.
module tb_seq_divider;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, count edges from the acceptance edge (inclusive) to out_valid, then retire it.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    op       = o;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = '0;
    op       = ~o;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    logic [63:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'b00;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_op("divu 100/7", 2'b01, 64'd100, 64'd7, 64'd14, 65);
    do_op("remu 100/7", 2'b11, 64'd100, 64'd7, 64'd2, 65);
    do_op("div -7/2", 2'b00, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("rem -7/2", 2'b10, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("rem 7/-2", 2'b10, 64'd7, -64'sd2, 64'd1, 65);
    do_op("div -100/-7", 2'b00, -64'sd100, -64'sd7, 64'd14, 65);
    do_op("divu max/msb", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 65);
    do_op("remu max/msb", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
          64'h7FFF_FFFF_FFFF_FFFE, 65);
    do_op("divu 5/0", 2'b01, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("rem 1234/0", 2'b10, 64'h1234, 64'd0, 64'h1234, 1);
    do_op("div ovf", 2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1);
    do_op("rem ovf", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);

    // Backpressure: hold the result in DONE for 10 cycles.
    op = 2'b01; dividend = 64'd1000; divisor = 64'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 200) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("hold first result", result, 64'd100);
    held = result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold result", result, held);
      chk("hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op("b2b divu 77/7", 2'b01, 64'd77, 64'd7, 64'd11, 65);

    // Reset in the middle of BUSY discards the operation.
    op = 2'b01; dividend = 64'd100; divisor = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset result", result, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("post-reset no out_valid", 64'(seen), 64'd0);
    do_op("divu 9/3", 2'b01, 64'd9, 64'd3, 64'd3, 65);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
